// File: rtl/rshift_rne_sat.sv
// rshift_rne_sat: two-stage requantizer that arithmetic-right-shifts a wide signed
// accumulator, rounds to nearest-even and saturates to a narrow signed result.
//
// Optional build macro: RSHIFT_RNE_SAT_CNT_EN adds a 16-bit saturation event counter.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset
//   in_valid_i     input sample valid
//   in_ready_o     stage accepts an input this cycle
//   in_data_i      IN_W-bit signed accumulator
//   in_shift_i     right-shift amount 0..IN_W-1
//   out_valid_o    result valid
//   out_ready_i    downstream accepts the result
//   out_data_o     OUT_W-bit signed rounded/saturated result
//   out_sat_o      result was clamped
//   sat_cnt_clr_i  (macro only) synchronous counter clear
//   sat_cnt_o      (macro only) saturating count of clamped output transfers

// redor: OR reduction of a W-bit vector.
module redor #(
   parameter int W = 8
) (
   input  logic [W-1:0] d_i,
   output logic         r_o
);
   assign r_o = |d_i;
endmodule

module rshift_rne_sat #(
   parameter int IN_W    = 64,
   parameter int OUT_W   = 8,
   parameter int SHIFT_W = $clog2(IN_W)
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic [IN_W-1:0]    in_data_i,
   input  logic [SHIFT_W-1:0] in_shift_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [OUT_W-1:0]   out_data_o,
   output logic               out_sat_o
`ifdef RSHIFT_RNE_SAT_CNT_EN
   ,
   input  logic               sat_cnt_clr_i,
   output logic [15:0]        sat_cnt_o
`endif
);
   // Clamp limits held in IN_W+1 bits so the rounded sum can be compared without wrap.
   localparam logic signed [IN_W:0] MAX_P = ((IN_W+1)'(1) << (OUT_W-1)) - (IN_W+1)'(1);
   localparam logic signed [IN_W:0] MIN_N = ~MAX_P;

   logic               en;
   logic [IN_W-1:0]    g_mask, stk_mask, stk_bits;
   logic [IN_W-1:0]    s1_data_d;
   logic               s1_guard_d, s1_sticky_d;
   logic               s1_valid_q, s1_guard_q, s1_sticky_q, s1_lsb_q;
   logic [IN_W-1:0]    s1_data_q;
   logic               inc, ovf_hi, ovf_lo;
   logic signed [IN_W:0] r;
   logic [OUT_W-1:0]   s2_data_d;
   logic               s2_sat_d;
   logic               s2_valid_q, s2_sat_q;
   logic [OUT_W-1:0]   s2_data_q;

   // A stage advances whenever the output register is empty or being drained.
   assign en         = ~s2_valid_q | out_ready_i;
   assign in_ready_o = en;

   // Guard is the bit just below the shift point; sticky covers everything beneath it.
   always_comb begin
      g_mask      = (in_shift_i == '0) ? '0 : (IN_W'(1) << (in_shift_i - SHIFT_W'(1)));
      stk_mask    = (in_shift_i < SHIFT_W'(2)) ? '0 : g_mask - IN_W'(1);
      stk_bits    = in_data_i & stk_mask;
      s1_data_d   = $signed(in_data_i) >>> in_shift_i;
      s1_guard_d  = |(in_data_i & g_mask);
   end

   redor #(.W(IN_W)) u_sticky (
      .d_i (stk_bits),
      .r_o (s1_sticky_d)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_valid_q  <= 1'b0;
         s1_data_q   <= '0;
         s1_guard_q  <= 1'b0;
         s1_sticky_q <= 1'b0;
         s1_lsb_q    <= 1'b0;
      end else if (en) begin
         s1_valid_q <= in_valid_i;
         if (in_valid_i) begin
            s1_data_q   <= s1_data_d;
            s1_guard_q  <= s1_guard_d;
            s1_sticky_q <= s1_sticky_d;
            s1_lsb_q    <= s1_data_d[0];
         end
      end
   end

   // Round up above half, or at exactly half when the truncated value is odd.
   always_comb begin
      inc       = s1_guard_q & (s1_sticky_q | s1_lsb_q);
      r         = {s1_data_q[IN_W-1], s1_data_q} + {{IN_W{1'b0}}, inc};
      ovf_hi    = r > MAX_P;
      ovf_lo    = r < MIN_N;
      s2_data_d = ovf_hi ? {1'b0, {(OUT_W-1){1'b1}}} :
                  ovf_lo ? {1'b1, {(OUT_W-1){1'b0}}} : r[OUT_W-1:0];
      s2_sat_d  = ovf_hi | ovf_lo;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         s2_sat_q   <= 1'b0;
      end else if (en) begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            s2_data_q <= s2_data_d;
            s2_sat_q  <= s2_sat_d;
         end
      end
   end

   assign out_valid_o = s2_valid_q;
   assign out_data_o  = s2_data_q;
   assign out_sat_o   = s2_sat_q;

`ifdef RSHIFT_RNE_SAT_CNT_EN
   logic [15:0] sat_cnt_q, sat_cnt_d;

   // Clear dominates; counting stops at all-ones instead of wrapping.
   always_comb begin
      sat_cnt_d = sat_cnt_clr_i ? '0 :
                  (s2_valid_q & out_ready_i & s2_sat_q & ~&sat_cnt_q) ? sat_cnt_q + 16'd1 : sat_cnt_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) sat_cnt_q <= '0;
      else         sat_cnt_q <= sat_cnt_d;
   end

   assign sat_cnt_o = sat_cnt_q;
`endif
endmodule

// File: doc/rshift_rne_sat.md
Name: rshift_rne_sat

Overview:
- Pipelined requantization stage for the non-linear ops datapath.
- Takes a wide signed accumulator and a per-sample right-shift amount. Produces a narrow signed result using round-to-nearest-even and saturation.
- Sticky-bit generation is an OR reduction over the shifted-out bits below the guard bit, instantiated from the team's `redor` block. This stage is the direct consumer of that reduction.
- Sits downstream of the MAC/accumulate stage and upstream of the activation LUT.

Parameters:
- IN_W, 64, input width in bits. Must be a power of 2, >= 8.
- OUT_W, 8, output width in bits. Must be >= 2 and < IN_W.
- SHIFT_W, $clog2(IN_W), shift-amount width. Derived; do not override.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- in_valid_i  input  1  input sample valid.
- in_ready_o  output  1  stage can accept an input this cycle.
- in_data_i  input  IN_W  signed two's-complement value.
- in_shift_i  input  SHIFT_W  right-shift amount, 0..IN_W-1; every encoding is legal.
- out_valid_o  output  1  result valid.
- out_ready_i  input  1  downstream accepts the result.
- out_data_o  output  OUT_W  signed rounded and saturated result.
- out_sat_o  output  1  result was clamped.

Behaviour:
- Reset is asynchronous, active-low.
  - While rst_ni=0: all valid flags = 0, out_data_o = 0, out_sat_o = 0, all pipeline data registers = 0.
  - Deassertion is used as-is; synchronising it is the integrator's job.
- Pipeline has 2 register stages, S1 and S2. S2 drives the outputs directly.
  - Latency is 2 cycles from input handshake to out_valid_o when there is no stall.
  - Throughput is 1 sample/cycle.
- Handshake:
  - en = ~s2_valid | out_ready_i; in_ready_o = en.
  - An input transfers when in_valid_i & in_ready_o.
  - An output transfers when out_valid_o & out_ready_i.
  - When en=0, S1 and S2 hold data and valid unchanged; nothing is dropped or duplicated.
  - S1 valid advancing into an empty S2 is allowed even when out_ready_i=0. This is a bubble collapse: en=1 because s2_valid=0.
  - out_data_o and out_sat_o stay stable while out_valid_o=1 and out_ready_i=0.
  - in_ready_o depends combinationally only on s2_valid and out_ready_i, never on in_valid_i.
- S1 (shift):
  - q = in_data_i >>> s (arithmetic shift).
  - guard = (s>0) ? in_data_i[s-1] : 0.
  - sticky = (s>1) ? |in_data_i[s-2:0] : 0, produced via `redor` on a masked copy of the input.
  - Register q, guard, sticky and q[0].
- S2 (round and saturate):
  - inc = guard & (sticky | q[0]).
  - r = sign-extended q + inc, computed in IN_W+1 bits so it never wraps.
  - If r > 2^(OUT_W-1)-1: out_data = max positive, sat = 1.
  - If r < -2^(OUT_W-1): out_data = min negative, sat = 1.
  - Otherwise: out_data = r[OUT_W-1:0], sat = 0.
- Boundaries:
  - s=0 passes the input through with no rounding; saturation still applies.
  - s=IN_W-1 yields q in {0,-1} and rounds correctly.
  - Exact ties round to even in both signs.
- Reset asserted mid-stream discards all in-flight samples. After release the pipeline is empty and in_ready_o=1.

Optional Feature:
- Macro: RSHIFT_RNE_SAT_CNT_EN.
- When defined, adds two ports:
  - sat_cnt_clr_i  input  1  synchronous clear.
  - sat_cnt_o  output  16  count of output transfers with out_sat_o=1.
- Counter behaviour:
  - Saturates at 0xFFFF; never wraps.
  - Resets to 0.
  - If clear and an increment occur in the same cycle, clear wins and the result is 0.
  - Counts only on the output handshake, never on a stalled hold.
- When undefined: the ports and counter are absent; the datapath is identical.

Test Plan (IN_W=64, OUT_W=8):
- Ties and rounding at s=2: x=10 -> 2; x=14 -> 4; x=13 -> 3; x=-10 -> -2; x=-14 -> -4. All with sat=0, out_valid 2 cycles after input handshake.
- Saturation at s=2: x=1000 -> 127 with sat=1; x=-1000 -> -128 with sat=1; x=508 -> 127 with sat=0.
- Shift extremes:
  - s=0, x=-5 -> -5.
  - s=0, x=200 -> 127 with sat=1.
  - s=63, x=2^62 -> 0 (tie, even).
  - s=63, x=2^62+1 -> 1.
  - s=63, x=-1 -> 0.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles with in_valid=1 and 3 samples offered.
  - Required: in_ready drops once S1 and S2 are full; outputs are held stable.
  - On out_ready=1, all 3 results emerge in order, 1 per cycle, with no loss or duplication.
- Reset mid-stream: assert rst_ni while 2 samples are in flight. Required: out_valid=0 immediately (asynchronous); the next post-reset input produces exactly one result.
- With RSHIFT_RNE_SAT_CNT_EN defined:
  - 3 saturating transfers -> sat_cnt=3.
  - Clear coincident with a saturating transfer -> 0.
  - Preload to 0xFFFF, then one more saturating transfer -> stays 0xFFFF.
